// File: rtl/adder_multicycle_pkg.sv
// Shared ALU definitions: adder FSM state encoding and chunk-counter sizing.
package adder_multicycle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n chunks; a single chunk still needs a 1-bit index.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells; also
// exposes the carry into the top bit so the caller can derive signed overflow.
module adder_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_multicycle.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock through a carry
// register, with valid/ready handshakes and carry/overflow/zero flags.
module adder_multicycle
  import adder_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned CNT_W      = cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, out_q, out_next;
  logic             carry_q;
  logic [CNT_W-1:0] idx_q;
  logic             cout_q, ovf_q, zero_q;

  logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
  logic             c_out, c_msb;
  logic             last;

  assign last = (idx_q == LAST_IDX);
  assign a_sl = a_q[idx_q*CHUNK +: CHUNK];
  assign b_sl = b_q[idx_q*CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry_q),
    .sum   (sum_sl),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // Result with the current chunk merged in, so zero sees the full word.
  always_comb begin
    out_next = out_q;
    out_next[idx_q*CHUNK +: CHUNK] = sum_sl;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and the +1 enters
  // through the initial carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          out_q   <= out_next;
          carry_q <= c_out;
          if (last) begin
            cout_q <= c_out;
            ovf_q  <= c_msb ^ c_out;
            zero_q <= (out_next == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = out_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
